interpolation_control_param: RTL and testbench
==============================================

INTERPOLATION_CONTROL_PARAM -- requirements
Module: interpolation_control_param

Interface
REQ-001 SHALL have parameter PH_CYCLES, default 16, meaning cycles spent in horizontal half-pel interpolation per block (>=1).
REQ-002 SHALL have parameter PVPO_CYCLES, default 6, meaning cycles in primary-vertical interpolation per block (>=1).
REQ-003 SHALL have parameter PVSO_CYCLES, default 26, meaning cycles in secondary-vertical (quarter-pel) interpolation per block (>=1).
REQ-004 SHALL have parameter BLK_W, default 8, meaning width of the block-count input.
REQ-005 SHALL have ports, one per line: clock in 1 system clock; reset in 1 asynchronous active-low reset; start in 1 run request; blk_count in BLK_W blocks per run; qp_en in 1 quarter-pel phases enabled; stall in 1 freeze; enable_reg_int, enable_SR_integer, enable_SR_horizontal, enable_read_integer, enable_read_horizontal, mux_c0, mux_c1, enable_clip, clip_pvso out 1 each, datapath controls; busy out 1 run in progress; done out 1 run-complete pulse.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-007 SHALL implement states IDLE, BEGIN, PH, PVPO_SETUP, PVPO, PVSO_SETUP, PVSO, BEGIN_PVSO.
REQ-008 SHALL drive controls as Moore outputs, bit order reg_int,SR_int,SR_h,read_int,read_h,c0,c1,clip,cp: IDLE 000000000; BEGIN 100000000; PH 111000010; PVPO_SETUP 111100010; PVPO 000100110; PVSO_SETUP 000110110; PVSO 000011111; BEGIN_PVSO 100011111.
REQ-009 SHALL, in IDLE, on start=1 with blk_count!=0, latch blk_count and qp_en and enter BEGIN next cycle; start with blk_count=0 SHALL be ignored.
REQ-010 SHALL ignore start while busy; latched qp_en/blk_count SHALL NOT change mid-run.
REQ-011 SHALL move BEGIN->PH, PVPO_SETUP->PVPO, PVSO_SETUP->PVSO, BEGIN_PVSO->PH after exactly one cycle.
REQ-012 SHALL hold PH for PH_CYCLES cycles, PVPO for PVPO_CYCLES, PVSO for PVSO_CYCLES, using an internal cycle counter cleared on every state entry; no external finished inputs.
REQ-013 SHALL, at PH end, enter PVPO_SETUP.
REQ-014 SHALL, at PVPO end with qp_en=1, enter PVSO_SETUP; with qp_en=0, enter BEGIN if blocks remain, else IDLE.
REQ-015 SHALL, at PVSO end, enter BEGIN_PVSO if blocks remain, else IDLE.
REQ-016 SHALL decrement the remaining-block count once per completed block; "blocks remain" means remaining >1 at that block's final cycle.
REQ-017 SHALL, while stall=1, freeze state, cycle counter and block counter, and force enable_reg_int, enable_SR_*, enable_read_*, enable_clip to 0; mux_c0, mux_c1, clip_pvso keep state values.
REQ-018 SHALL assert busy whenever state!=IDLE.
REQ-019 SHALL pulse done high for exactly one cycle: the first IDLE cycle after a run completes; never otherwise.
REQ-020 SHALL size the cycle counter to hold max(PH_CYCLES,PVPO_CYCLES,PVSO_CYCLES)-1 without wrap.

Reset
REQ-021 SHALL, on reset=0, asynchronously force state IDLE, counters 0, latched qp_en 0, all outputs 0 including busy and done.
REQ-022 SHALL abandon any run on mid-operation reset without emitting done; first post-reset run behaves identically to a power-on run.

Structure
REQ-023 SHALL place state encoding, default cycle constants and control-vector bit indices in shared package fme_pkg.
REQ-024 SHALL implement the per-phase cycle counter as sub-module fme_phase_counter (load/clear, enable, terminal-count flag); remaining logic stays in one module.

Verification
REQ-025 Defaults, start=1, blk_count=1, qp_en=1 -> busy 51 cycles (BEGIN1,PH16,SETUP1,PVPO6,SETUP1,PVSO26), done one cycle after, control vectors per REQ-008 each cycle.
REQ-026 blk_count=3, qp_en=1 -> 153 busy cycles, BEGIN_PVSO appears exactly twice (cycles 52,103 of run), single done.
REQ-027 blk_count=2, qp_en=0 -> 48 busy cycles, PVSO/PVSO_SETUP/BEGIN_PVSO never entered, clip_pvso never 1.
REQ-028 stall=1 for 5 cycles in PH cycle 8 -> enables 0 during stall, busy 56 cycles total, sequence otherwise unchanged.
REQ-029 start with blk_count=0 -> stays IDLE; start pulsed during PVPO -> ignored, latched count unaffected.
REQ-030 reset=0 during PVSO cycle 10 -> all outputs 0 immediately, no done; new start afterwards gives 51-cycle run.

Source files
------------

// File: rtl/fme_pkg.sv
// Shared definitions for the fractional-motion-estimation interpolation controller:
// state encoding, default phase lengths and control-vector layout.
package fme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEGIN,
    S_PH,
    S_PVPO_SETUP,
    S_PVPO,
    S_PVSO_SETUP,
    S_PVSO,
    S_BEGIN_PVSO
  } fme_state_e;

  localparam int unsigned PH_CYCLES_DEF   = 16;
  localparam int unsigned PVPO_CYCLES_DEF = 6;
  localparam int unsigned PVSO_CYCLES_DEF = 26;

  localparam int unsigned CTL_W        = 9;
  localparam int unsigned CTL_REG_INT  = 8;
  localparam int unsigned CTL_SR_INT   = 7;
  localparam int unsigned CTL_SR_H     = 6;
  localparam int unsigned CTL_READ_INT = 5;
  localparam int unsigned CTL_READ_H   = 4;
  localparam int unsigned CTL_C0       = 3;
  localparam int unsigned CTL_C1       = 2;
  localparam int unsigned CTL_CLIP     = 1;
  localparam int unsigned CTL_CP       = 0;

  // Bits that a stall forces low; the mux selects keep their state values.
  localparam logic [CTL_W-1:0] CTL_ENABLE_MASK = 9'b111110010;

  function automatic logic [CTL_W-1:0] ctl_for_state(fme_state_e s);
    logic [CTL_W-1:0] v;
    case (s)
      S_BEGIN:      v = 9'b100000000;
      S_PH:         v = 9'b111000010;
      S_PVPO_SETUP: v = 9'b111100010;
      S_PVPO:       v = 9'b000100110;
      S_PVSO_SETUP: v = 9'b000110110;
      S_PVSO:       v = 9'b000011111;
      S_BEGIN_PVSO: v = 9'b100011111;
      default:      v = '0;
    endcase
    return v;
  endfunction

  function automatic int unsigned cnt_width(int unsigned max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/fme_phase_counter.sv
// Per-phase cycle counter: synchronous clear, count enable and a terminal-count flag
// raised when the count equals the phase's last cycle index.
module fme_phase_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/interpolation_control_param.sv
// Sequencer for half-pel / quarter-pel interpolation: walks each block through
// horizontal, primary-vertical and optional secondary-vertical phases.
module interpolation_control_param
  import fme_pkg::*;
#(
  parameter int unsigned PH_CYCLES   = PH_CYCLES_DEF,
  parameter int unsigned PVPO_CYCLES = PVPO_CYCLES_DEF,
  parameter int unsigned PVSO_CYCLES = PVSO_CYCLES_DEF,
  parameter int unsigned BLK_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BLK_W-1:0] blk_count,
  input  logic             qp_en,
  input  logic             stall,
  output logic             enable_reg_int,
  output logic             enable_SR_integer,
  output logic             enable_SR_horizontal,
  output logic             enable_read_integer,
  output logic             enable_read_horizontal,
  output logic             mux_c0,
  output logic             mux_c1,
  output logic             enable_clip,
  output logic             clip_pvso,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MAX_A   = (PH_CYCLES > PVPO_CYCLES) ? PH_CYCLES : PVPO_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > PVSO_CYCLES) ? MAX_A : PVSO_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(MAX_CYC);

  localparam logic [CNT_W-1:0] PH_LAST   = CNT_W'(PH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PVPO_LAST = CNT_W'(PVPO_CYCLES - 1);
  localparam logic [CNT_W-1:0] PVSO_LAST = CNT_W'(PVSO_CYCLES - 1);

  fme_state_e       state_q, state_d;
  logic [BLK_W-1:0] remaining_q;
  logic             qp_q;
  logic             done_q;

  logic             load, blk_dec, run_end;
  logic             cnt_clear, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_last, cnt_val;
  logic             counting, more_blocks;
  logic [CTL_W-1:0] ctl;

  assign more_blocks = (remaining_q > BLK_W'(1));

  always_comb begin
    counting = 1'b0;
    cnt_last = '0;
    case (state_q)
      S_PH:    begin counting = 1'b1; cnt_last = PH_LAST;   end
      S_PVPO:  begin counting = 1'b1; cnt_last = PVPO_LAST; end
      S_PVSO:  begin counting = 1'b1; cnt_last = PVSO_LAST; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    blk_dec = 1'b0;
    run_end = 1'b0;
    if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (start && (blk_count != '0)) begin
            load    = 1'b1;
            state_d = S_BEGIN;
          end
        end
        S_BEGIN, S_BEGIN_PVSO: state_d = S_PH;
        S_PH:         if (cnt_tc) state_d = S_PVPO_SETUP;
        S_PVPO_SETUP: state_d = S_PVPO;
        S_PVPO: begin
          if (cnt_tc) begin
            if (qp_q) begin
              state_d = S_PVSO_SETUP;
            end else if (more_blocks) begin
              state_d = S_BEGIN;
              blk_dec = 1'b1;
            end else begin
              state_d = S_IDLE;
              run_end = 1'b1;
            end
          end
        end
        S_PVSO_SETUP: state_d = S_PVSO;
        S_PVSO: begin
          if (cnt_tc) begin
            if (more_blocks) begin
              state_d = S_BEGIN_PVSO;
              blk_dec = 1'b1;
            end else begin
              state_d = S_IDLE;
              run_end = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Clearing on every state change gives each phase a fresh count from zero.
  assign cnt_clear = !stall && (state_d != state_q);
  assign cnt_en    = !stall && counting;

  fme_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .last   (cnt_last),
    .count  (cnt_val),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      qp_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= run_end;
      if (load) begin
        remaining_q <= blk_count;
        qp_q        <= qp_en;
      end else if (blk_dec) begin
        remaining_q <= remaining_q - BLK_W'(1);
      end else if (run_end) begin
        remaining_q <= '0;
      end
    end
  end

  always_comb begin
    ctl = ctl_for_state(state_q);
    if (stall) ctl = ctl & ~CTL_ENABLE_MASK;
  end

  assign enable_reg_int         = ctl[CTL_REG_INT];
  assign enable_SR_integer      = ctl[CTL_SR_INT];
  assign enable_SR_horizontal   = ctl[CTL_SR_H];
  assign enable_read_integer    = ctl[CTL_READ_INT];
  assign enable_read_horizontal = ctl[CTL_READ_H];
  assign mux_c0                 = ctl[CTL_C0];
  assign mux_c1                 = ctl[CTL_C1];
  assign enable_clip            = ctl[CTL_CLIP];
  assign clip_pvso              = ctl[CTL_CP];
  assign busy                   = (state_q != S_IDLE);
  assign done                   = done_q;

endmodule

// File: tb/tb_interpolation_control_param.sv
// Self-checking bench for interpolation_control_param: per-cycle control vectors
// compared against a phase-list model built from block count, qp_en and stalls.
module tb_interpolation_control_param;

  localparam int PH   = 16;
  localparam int PVPO = 6;
  localparam int PVSO = 26;
  localparam int BW   = 8;

  localparam logic [8:0] V_BEGIN      = 9'b100000000;
  localparam logic [8:0] V_PH         = 9'b111000010;
  localparam logic [8:0] V_PVPO_SETUP = 9'b111100010;
  localparam logic [8:0] V_PVPO       = 9'b000100110;
  localparam logic [8:0] V_PVSO_SETUP = 9'b000110110;
  localparam logic [8:0] V_PVSO       = 9'b000011111;
  localparam logic [8:0] V_BEGIN_PVSO = 9'b100011111;
  localparam logic [8:0] KEEP_ON_STALL = 9'b000001101;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [BW-1:0] blk_count;
  logic          qp_en;
  logic          stall;
  logic enable_reg_int, enable_SR_integer, enable_SR_horizontal;
  logic enable_read_integer, enable_read_horizontal;
  logic mux_c0, mux_c1, enable_clip, clip_pvso, busy, done;
  logic [8:0] dut_ctl;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  always #5 clock = ~clock;

  interpolation_control_param #(
    .PH_CYCLES   (PH),
    .PVPO_CYCLES (PVPO),
    .PVSO_CYCLES (PVSO),
    .BLK_W       (BW)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .blk_count              (blk_count),
    .qp_en                  (qp_en),
    .stall                  (stall),
    .enable_reg_int         (enable_reg_int),
    .enable_SR_integer      (enable_SR_integer),
    .enable_SR_horizontal   (enable_SR_horizontal),
    .enable_read_integer    (enable_read_integer),
    .enable_read_horizontal (enable_read_horizontal),
    .mux_c0                 (mux_c0),
    .mux_c1                 (mux_c1),
    .enable_clip            (enable_clip),
    .clip_pvso              (clip_pvso),
    .busy                   (busy),
    .done                   (done)
  );

  assign dut_ctl = {enable_reg_int, enable_SR_integer, enable_SR_horizontal,
                    enable_read_integer, enable_read_horizontal,
                    mux_c0, mux_c1, enable_clip, clip_pvso};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected per-cycle vectors of a run: phase list per block, stall cycles
  // repeat the frozen cycle with its enables dropped.
  task automatic build_expected(input int b, input bit q, input int sa, input int sl);
    logic [8:0] frozen;
    exp_q.delete();
    for (int blk = 0; blk < b; blk++) begin
      exp_q.push_back((blk == 0 || !q) ? V_BEGIN : V_BEGIN_PVSO);
      for (int i = 0; i < PH; i++) exp_q.push_back(V_PH);
      exp_q.push_back(V_PVPO_SETUP);
      for (int i = 0; i < PVPO; i++) exp_q.push_back(V_PVPO);
      if (q) begin
        exp_q.push_back(V_PVSO_SETUP);
        for (int i = 0; i < PVSO; i++) exp_q.push_back(V_PVSO);
      end
    end
    if (sl > 0) begin
      frozen = exp_q[sa] & KEEP_ON_STALL;
      for (int i = 0; i < sl; i++) exp_q.insert(sa, frozen);
    end
  endtask

  task automatic run_check(input string name, input int b, input bit q,
                           input int sa, input int sl, input int mid);
    int n;
    build_expected(b, q, sa, sl);
    n = exp_q.size();
    start = 1'b1; blk_count = BW'(b); qp_en = q; stall = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < n; c++) begin
      stall = (sl > 0 && c >= sa && c < sa + sl);
      if (c == mid) begin
        start = 1'b1;
        blk_count = BW'($urandom_range(1, 5));
        qp_en = ~q;
      end else begin
        start = 1'b0;
      end
      #1;
      checks++;
      if ({dut_ctl, busy, done} !== {exp_q[c], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s cycle %0d: ctl=%b busy=%b done=%b, required ctl=%b busy=1 done=0",
                 name, c, dut_ctl, busy, done, exp_q[c]);
      end
      step();
    end
    stall = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({dut_ctl, busy, done} !== {9'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s done_cycle: ctl=%b busy=%b done=%b, required ctl=0 busy=0 done=1",
               name, dut_ctl, busy, done);
    end
    step();
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_done: busy=%b done=%b, required 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; blk_count = '0; qp_en = 1'b0; stall = 1'b0;
    #2;
    checks++;
    if ({dut_ctl, busy, done} !== 11'b0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b, required all 0", {dut_ctl, busy, done});
    end
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_block();
    run_check("single_qp", 1, 1'b1, 0, 0, -1);
  endtask

  task automatic test_multi_block();
    run_check("three_qp", 3, 1'b1, 0, 0, -1);
    run_check("two_noqp", 2, 1'b0, 0, 0, -1);
  endtask

  task automatic test_stall();
    run_check("stall_ph8", 1, 1'b1, 8, 5, -1);
  endtask

  task automatic test_ignored_start();
    start = 1'b1; blk_count = '0; qp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL zero_count_start %0d: busy=%b done=%b, required 0 0", i, busy, done);
      end
    end
    start = 1'b0;
    // start during PVPO (cycle 20) with a different count and qp_en
    run_check("start_in_pvpo", 2, 1'b1, 0, 0, 20);
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; blk_count = 8'd1; qp_en = 1'b1; stall = 1'b0;
    step();
    start = 1'b0;
    repeat (34) step();
    reset = 1'b0;
    #1;
    checks++;
    if ({dut_ctl, busy, done} !== 11'b0) begin
      errors++;
      $display("FAIL reset_midrun: outputs=%b, required all 0", {dut_ctl, busy, done});
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_idle %0d: busy=%b done=%b, required 0 0", i, busy, done);
      end
    end
    run_check("post_reset_run", 1, 1'b1, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int b, len, sa, sl, mid;
      bit q;
      b   = $urandom_range(1, 3);
      q   = 1'($urandom_range(0, 1));
      len = b * (q ? (2 + PH + PVPO + 1 + PVSO) : (2 + PH + PVPO));
      sa  = $urandom_range(1, len - 2);
      sl  = $urandom_range(0, 4);
      mid = $urandom_range(1, len - 2);
      run_check($sformatf("random%0d_b%0d_q%0d", r, b, q), b, q, sa, sl, mid);
    end
  endtask

  task automatic test_back_to_back();
    run_check("b2b_first", 1, 1'b0, 0, 0, -1);
    run_check("b2b_second", 1, 1'b1, 3, 2, -1);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_multi_block();
    test_stall();
    test_ignored_start();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
